// File: rtl/rm_hdr_pkg.sv
// Shared definitions for the header-removal stage.
//   CTRL_IOQ_HDR : ctrl value carried by the IOQ module header.
//   log2c        : ceiling log2, used to size FIFO pointers.
//   occ_w        : occupancy counter width for a FIFO of a given depth
//                  (one extra bit so the full count is representable).
package rm_hdr_pkg;

  localparam logic [7:0] CTRL_IOQ_HDR = 8'hFF;

  function automatic int log2c(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int occ_w(input int depth);
    return log2c(depth) + 1;
  endfunction

endpackage

// File: rtl/rm_hdr_sfifo.sv
// Synchronous FIFO with a registered read port.
//   clk, reset : clock and asynchronous active-low reset
//   wr, din    : write strobe and word; ignored while full
//   rd         : read strobe; ignored while empty
//   dout       : word loaded on the cycle after an accepted read, held otherwise
//   empty/full : occupancy == 0 / occupancy == DEPTH
//   occupancy  : number of stored words
module rm_hdr_sfifo
  import rm_hdr_pkg::*;
#(
  parameter int WIDTH = 72,
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr,
  input  logic                    rd,
  input  logic [WIDTH-1:0]        din,
  output logic [WIDTH-1:0]        dout,
  output logic                    empty,
  output logic                    full,
  output logic [occ_w(DEPTH)-1:0] occupancy
);

  localparam int AW = log2c(DEPTH);
  localparam int OW = occ_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  assign empty = (occupancy == '0);
  assign full  = (occupancy == OW'(DEPTH));

  // A write into a full FIFO is dropped even if a read frees a slot in the
  // same cycle; this keeps the overflow decision purely registered.
  assign wr_ok = wr && !full;
  assign rd_ok = rd && !empty;

  // Storage array carries data only, so it needs no reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   occupancy <= occupancy + OW'(1);
        2'b01:   occupancy <= occupancy - OW'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Output register: downstream sees an all-zero word after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout <= '0;
    end else if (rd_ok) begin
      dout <= mem[rd_ptr];
    end
  end

endmodule

// File: rtl/rm_hdr_flex.sv
// Header-removal stage with runtime strip enable, a always-kept header type,
// statistics counters and almost-full back-pressure.
//   clk, reset             : clock, asynchronous active-low reset
//   in_data/in_ctrl/in_wr  : upstream word; in_rdy says upstream may write
//   out_data/out_ctrl/out_wr : downstream word; out_rdy says it can accept
//   strip_en               : 1 strips non-kept headers, 0 passes every word
//   cnt_clr                : synchronous clear of counters and overflow
//   hdr_drop_cnt, pkt_cnt  : dropped-header and written-EOP counts (wrapping)
//   overflow               : sticky, a word was offered while the FIFO was full
module rm_hdr_flex
  import rm_hdr_pkg::*;
#(
  parameter int                  DATA_WIDTH    = 64,
  parameter int                  CTRL_WIDTH    = DATA_WIDTH / 8,
  parameter int                  FIFO_DEPTH    = 16,
  parameter int                  AF_MARGIN     = 3,
  parameter int                  KEEP_HDR_EN   = 1,
  parameter logic [CTRL_WIDTH-1:0] KEEP_HDR_CTRL = CTRL_WIDTH'(CTRL_IOQ_HDR),
  parameter int                  CNT_WIDTH     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  input  logic                  strip_en,
  input  logic                  cnt_clr,
  output logic [CNT_WIDTH-1:0]  hdr_drop_cnt,
  output logic [CNT_WIDTH-1:0]  pkt_cnt,
  output logic                  overflow
);

  localparam int OW = occ_w(FIFO_DEPTH);
  localparam int FW = CTRL_WIDTH + DATA_WIDTH;

  logic          in_pkt;
  logic          ctrl_nz;
  logic          is_hdr;
  logic          is_eop;
  logic          keep;
  logic          hdr_drop;
  logic          fifo_wr;
  logic          fifo_rd;
  logic          wr_lost;
  logic          eop_written;
  logic          empty;
  logic          full;
  logic [OW-1:0] occ;
  logic          vld_p1;

  // ---- stage p0: classify the incoming word ----
  // A nonzero ctrl means "header" outside a packet and "EOP" inside one.
  assign ctrl_nz     = |in_ctrl;
  assign is_hdr      = in_wr && !in_pkt && ctrl_nz;
  assign is_eop      = in_wr && in_pkt && ctrl_nz;
  assign keep        = !strip_en || ((KEEP_HDR_EN != 0) && (in_ctrl == KEEP_HDR_CTRL));
  assign hdr_drop    = is_hdr && !keep;
  assign fifo_wr     = in_wr && (!is_hdr || keep);
  assign wr_lost     = fifo_wr && full;
  assign eop_written = is_eop && fifo_wr && !full;
  assign fifo_rd     = out_rdy && !empty;

  // Threshold leaves AF_MARGIN free slots for writes already in flight.
  assign in_rdy = (occ < OW'(FIFO_DEPTH - AF_MARGIN));

  // Packet tracking follows every offered word, including ones lost to
  // overflow, so framing stays aligned with what upstream believes it sent.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_pkt <= 1'b0;
    end else if (in_wr) begin
      if (!in_pkt && !ctrl_nz)     in_pkt <= 1'b1;
      else if (in_pkt && ctrl_nz)  in_pkt <= 1'b0;
    end
  end

  // Clear takes priority over a same-cycle increment or overflow event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hdr_drop_cnt <= '0;
      pkt_cnt      <= '0;
      overflow     <= 1'b0;
    end else if (cnt_clr) begin
      hdr_drop_cnt <= '0;
      pkt_cnt      <= '0;
      overflow     <= 1'b0;
    end else begin
      if (hdr_drop)    hdr_drop_cnt <= hdr_drop_cnt + CNT_WIDTH'(1);
      if (eop_written) pkt_cnt      <= pkt_cnt + CNT_WIDTH'(1);
      if (wr_lost)     overflow     <= 1'b1;
    end
  end

  // ---- stage p1: FIFO storage and registered read ----
  rm_hdr_sfifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr        (fifo_wr),
    .rd        (fifo_rd),
    .din       ({in_ctrl, in_data}),
    .dout      ({out_ctrl, out_data}),
    .empty     (empty),
    .full      (full),
    .occupancy (occ)
  );

  // Valid tracks the FIFO output register, which loads on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= fifo_rd;
    end
  end

  assign out_wr = vld_p1;

endmodule

// File: tb/tb_rm_hdr_flex.sv
module tb_rm_hdr_flex;

  localparam int DW = 64;
  localparam int CW = 8;
  localparam int NW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          in_wr;
  logic          in_rdy;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic          out_wr;
  logic          out_rdy;
  logic          strip_en;
  logic          cnt_clr;
  logic [NW-1:0] hdr_drop_cnt;
  logic [NW-1:0] pkt_cnt;
  logic          overflow;

  always #5 clk = ~clk;

  rm_hdr_flex dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_ctrl      (in_ctrl),
    .in_wr        (in_wr),
    .in_rdy       (in_rdy),
    .out_data     (out_data),
    .out_ctrl     (out_ctrl),
    .out_wr       (out_wr),
    .out_rdy      (out_rdy),
    .strip_en     (strip_en),
    .cnt_clr      (cnt_clr),
    .hdr_drop_cnt (hdr_drop_cnt),
    .pkt_cnt      (pkt_cnt),
    .overflow     (overflow)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int first_out = -1;
  bit arm = 1'b0;
  logic [CW+DW-1:0] sb[$];

  // Advance one cycle; outputs are checked against the scoreboard at the
  // falling edge, inputs change 1 time unit after the rising edge.
  task automatic tick();
    logic [CW+DW-1:0] exp_w;
    @(negedge clk);
    if (reset === 1'b1 && out_wr === 1'b1) begin
      if (arm && first_out < 0) first_out = cyc;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL out_word: got ctrl=%h data=%h, required no output", out_ctrl, out_data);
      end else begin
        exp_w = sb.pop_front();
        if ({out_ctrl, out_data} !== exp_w) begin
          bad++;
          $display("FAIL out_word: got ctrl=%h data=%h, required ctrl=%h data=%h",
                   out_ctrl, out_data, exp_w[CW+DW-1:DW], exp_w[DW-1:0]);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic put(input logic [DW-1:0] d, input logic [CW-1:0] c, input bit exp);
    in_wr   = 1'b1;
    in_data = d;
    in_ctrl = c;
    if (exp) sb.push_back({c, d});
    tick();
  endtask

  task automatic idle();
    in_wr   = 1'b0;
    in_data = '0;
    in_ctrl = '0;
  endtask

  task automatic clr_cnt();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0) break;
      tick();
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d words outstanding, required 0", sb.size());
      sb.delete();
    end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    idle();
    out_rdy  = 1'b0;
    strip_en = 1'b1;
    cnt_clr  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_wr !== 1'b0)     begin bad++; $display("FAIL rst_out_wr: got %b, required 0", out_wr); end
    total++; if (out_data !== '0)     begin bad++; $display("FAIL rst_out_data: got %h, required 0", out_data); end
    total++; if (out_ctrl !== '0)     begin bad++; $display("FAIL rst_out_ctrl: got %h, required 0", out_ctrl); end
    total++; if (hdr_drop_cnt !== '0) begin bad++; $display("FAIL rst_hdr_drop_cnt: got %0d, required 0", hdr_drop_cnt); end
    total++; if (pkt_cnt !== '0)      begin bad++; $display("FAIL rst_pkt_cnt: got %0d, required 0", pkt_cnt); end
    total++; if (overflow !== 1'b0)   begin bad++; $display("FAIL rst_overflow: got %b, required 0", overflow); end
    reset = 1'b1;
    tick();
    total++; if (in_rdy !== 1'b1)     begin bad++; $display("FAIL rst_in_rdy: got %b, required 1", in_rdy); end
  endtask

  task automatic test_strip();
    int d0;
    strip_en = 1'b1;
    out_rdy  = 1'b1;
    clr_cnt();
    arm = 1'b1;
    first_out = -1;
    d0 = cyc;
    put(64'hA000_0000_0000_00FF, 8'hFF, 1'b1);
    put(64'hA000_0000_0000_0002, 8'h02, 1'b0);
    put(64'hA111_1111_1111_1111, 8'h00, 1'b1);
    put(64'hA222_2222_2222_2222, 8'h00, 1'b1);
    put(64'hA333_3333_3333_3333, 8'h00, 1'b1);
    put(64'hA444_4444_4444_4444, 8'h10, 1'b1);
    idle();
    wait_drain();
    arm = 1'b0;
    total++; if (first_out - d0 != 2) begin bad++; $display("FAIL strip_latency: got %0d, required 2", first_out - d0); end
    total++; if (hdr_drop_cnt !== 32'd1) begin bad++; $display("FAIL strip_hdr_drop_cnt: got %0d, required 1", hdr_drop_cnt); end
    total++; if (pkt_cnt !== 32'd1) begin bad++; $display("FAIL strip_pkt_cnt: got %0d, required 1", pkt_cnt); end
  endtask

  task automatic test_passthrough();
    strip_en = 1'b0;
    out_rdy  = 1'b1;
    clr_cnt();
    put(64'hB000_0000_0000_00FF, 8'hFF, 1'b1);
    put(64'hB000_0000_0000_0002, 8'h02, 1'b1);
    put(64'hB111_1111_1111_1111, 8'h00, 1'b1);
    put(64'hB222_2222_2222_2222, 8'h00, 1'b1);
    put(64'hB333_3333_3333_3333, 8'h00, 1'b1);
    put(64'hB444_4444_4444_4444, 8'h10, 1'b1);
    idle();
    wait_drain();
    total++; if (hdr_drop_cnt !== 32'd0) begin bad++; $display("FAIL pass_hdr_drop_cnt: got %0d, required 0", hdr_drop_cnt); end
    total++; if (pkt_cnt !== 32'd1) begin bad++; $display("FAIL pass_pkt_cnt: got %0d, required 1", pkt_cnt); end
    strip_en = 1'b1;
  endtask

  task automatic test_af_overflow();
    int n;
    strip_en = 1'b1;
    out_rdy  = 1'b0;
    clr_cnt();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!in_rdy) break;
      put(64'hC000_0000_0000_0000 + 64'(n), 8'h00, 1'b1);
      n++;
    end
    total++; if (n != 13) begin bad++; $display("FAIL af_writes_before_rdy_low: got %0d, required 13", n); end
    for (int i = 0; i < 3; i++) put(64'hC100_0000_0000_0000 + 64'(i), 8'h00, 1'b1);
    idle();
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL af_margin_overflow: got %b, required 0", overflow); end
    total++; if (in_rdy !== 1'b0)   begin bad++; $display("FAIL af_in_rdy_full: got %b, required 0", in_rdy); end
    put(64'hC2EE_EEEE_EEEE_EEEE, 8'h10, 1'b0);
    idle();
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b, required 1", overflow); end
    total++; if (pkt_cnt !== 32'd0) begin bad++; $display("FAIL ovf_pkt_cnt: got %0d, required 0", pkt_cnt); end
    out_rdy = 1'b1;
    wait_drain();
    total++; if (in_rdy !== 1'b1)   begin bad++; $display("FAIL af_in_rdy_drained: got %b, required 1", in_rdy); end
  endtask

  task automatic test_cnt_clr();
    strip_en = 1'b1;
    out_rdy  = 1'b1;
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL clr_pre_overflow: got %b, required 1", overflow); end
    put(64'hD000_0000_0000_0002, 8'h02, 1'b0);
    idle();
    total++; if (hdr_drop_cnt !== 32'd1) begin bad++; $display("FAIL clr_pre_drop: got %0d, required 1", hdr_drop_cnt); end
    cnt_clr = 1'b1;
    put(64'hD000_0000_0000_0003, 8'h03, 1'b0);
    cnt_clr = 1'b0;
    idle();
    total++; if (hdr_drop_cnt !== 32'd0) begin bad++; $display("FAIL clr_drop_cnt: got %0d, required 0", hdr_drop_cnt); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL clr_overflow: got %b, required 0", overflow); end
    put(64'hD000_0000_0000_0004, 8'h04, 1'b0);
    idle();
    total++; if (hdr_drop_cnt !== 32'd1) begin bad++; $display("FAIL clr_resume: got %0d, required 1", hdr_drop_cnt); end
  endtask

  task automatic test_back_to_back();
    strip_en = 1'b1;
    out_rdy  = 1'b0;
    clr_cnt();
    for (int i = 0; i < 8; i++) put(64'hE000_0000_0000_0000 + 64'(i), 8'h00, 1'b1);
    total++; if (dut.occ !== 5'd8) begin bad++; $display("FAIL b2b_fill: got %0d, required 8", dut.occ); end
    out_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      put(64'hE100_0000_0000_0000 + 64'(i), (i == 19) ? 8'h10 : 8'h00, 1'b1);
      total++;
      if (dut.occ !== 5'd8) begin bad++; $display("FAIL b2b_occ: got %0d, required 8 (cycle %0d)", dut.occ, i); end
    end
    idle();
    wait_drain();
    total++; if (pkt_cnt !== 32'd1) begin bad++; $display("FAIL b2b_pkt_cnt: got %0d, required 1", pkt_cnt); end
  endtask

  task automatic test_reset_mid_packet();
    strip_en = 1'b1;
    out_rdy  = 1'b1;
    clr_cnt();
    put(64'hF111_1111_1111_1111, 8'h00, 1'b1);
    put(64'hF222_2222_2222_2222, 8'h00, 1'b1);
    idle();
    total++; if (out_wr !== 1'b1) begin bad++; $display("FAIL mid_pre_out_wr: got %b, required 1", out_wr); end
    reset = 1'b0;
    #1;
    total++; if (out_wr !== 1'b0) begin bad++; $display("FAIL mid_rst_out_wr: got %b, required 0", out_wr); end
    total++; if (dut.occ !== 5'd0) begin bad++; $display("FAIL mid_rst_occ: got %0d, required 0", dut.occ); end
    sb.delete();
    repeat (2) tick();
    reset = 1'b1;
    tick();
    put(64'hF000_0000_0000_0002, 8'h02, 1'b0);
    idle();
    total++; if (hdr_drop_cnt !== 32'd1) begin bad++; $display("FAIL mid_hdr_dropped: got %0d, required 1", hdr_drop_cnt); end
    put(64'hF333_3333_3333_3333, 8'h00, 1'b1);
    put(64'hF444_4444_4444_4444, 8'h10, 1'b1);
    idle();
    wait_drain();
    total++; if (pkt_cnt !== 32'd1) begin bad++; $display("FAIL mid_pkt_cnt: got %0d, required 1", pkt_cnt); end
  endtask

  initial begin
    test_reset();
    test_strip();
    test_passthrough();
    test_af_overflow();
    test_cnt_clr();
    test_back_to_back();
    test_reset_mid_packet();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rm_hdr_flex.md
Name: rm_hdr_flex

Overview:
Parametrised successor to the header-removal stage in the datapath pipeline. It strips module-header words from the ctrl/data stream ahead of the output queues, with two additions:
- a runtime strip-enable, plus one header type that is always kept;
- drop and packet statistics counters.
It buffers words in a depth-parametrised synchronous FIFO with configurable almost-full back-pressure, and reports overflow if upstream ignores in_rdy.

Parameters:
DATA_WIDTH, 64, data bus width in bits
CTRL_WIDTH, DATA_WIDTH/8, ctrl bus width in bits
FIFO_DEPTH, 16, FIFO entries; power of 2, at least 4
AF_MARGIN, 3, free entries still available when in_rdy deasserts; range 1..FIFO_DEPTH-1
KEEP_HDR_EN, 1, when 1, header words with ctrl==KEEP_HDR_CTRL are never stripped
KEEP_HDR_CTRL, 'hFF, ctrl value of the preserved header (IOQ header)
CNT_WIDTH, 32, statistics counter width

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-low (asserted at 0)
in_data  in  DATA_WIDTH  input word
in_ctrl  in  CTRL_WIDTH  input ctrl; nonzero outside a packet = header word, nonzero inside a packet = EOP word
in_wr  in  1  input word valid
in_rdy  out  1  upstream may write next cycle
out_data  out  DATA_WIDTH  output word
out_ctrl  out  CTRL_WIDTH  output ctrl
out_wr  out  1  output word valid
out_rdy  in  1  downstream can accept
strip_en  in  1  1 = strip non-kept headers; 0 = pass all words
cnt_clr  in  1  synchronous clear of the counters and the overflow flag
hdr_drop_cnt  out  CNT_WIDTH  header words discarded
pkt_cnt  out  CNT_WIDTH  EOP words written into the FIFO
overflow  out  1  sticky: a word arrived while the FIFO was full

Behaviour:
Reset (reset==0, asynchronous):
- in_pkt=0, FIFO emptied.
- out_wr=0, out_data=0, out_ctrl=0.
- Counters 0, overflow=0.
- in_rdy=1 once reset is released.

Packet tracking, on each in_wr:
- !in_pkt && in_ctrl==0: set in_pkt (first payload word).
- in_pkt && in_ctrl!=0: clear in_pkt (EOP word).
- Otherwise no change.

Word classification:
- Header word = in_wr && !in_pkt && in_ctrl!=0.
- Keep = !strip_en || (KEEP_HDR_EN && in_ctrl==KEEP_HDR_CTRL).
- strip_en is sampled per word.

Write path:
- fifo_wr = in_wr && (!header || keep).
- A dropped header increments hdr_drop_cnt.
- fifo_wr while full: the word is discarded even if a read happens in the same cycle, and overflow is set. in_pkt still updates.

pkt_cnt increments when an EOP word is actually written into the FIFO.

Counters:
- Wrap at 2^CNT_WIDTH.
- cnt_clr wins over a same-cycle increment; the result is 0.

Flow control:
- in_rdy = (occupancy < FIFO_DEPTH-AF_MARGIN), computed from registered occupancy.
- Upstream may issue up to AF_MARGIN writes after in_rdy falls without loss.

Read path:
- rd = out_rdy && !empty.
- out_wr, out_data and out_ctrl are registered from the read, one cycle later.
- out_wr=0 otherwise; out_data and out_ctrl hold their last value.

Occupancy:
- Simultaneous read and write with 0 < occupancy < FIFO_DEPTH: occupancy unchanged.
- Write to an empty FIFO: the word is readable the next cycle.
- Minimum in-to-out latency is 2 cycles.

Pointers are log2(FIFO_DEPTH) bits and wrap naturally; occupancy is log2(FIFO_DEPTH)+1 bits.

A packet with no headers passes unchanged. Header-only sequences (no payload) are dropped or kept word by word.

Decomposition:
Package rm_hdr_pkg:
- CTRL_IOQ_HDR='hFF
- log2 function
- occupancy width helper

Sub-module rm_hdr_sfifo: parametrised width/depth synchronous FIFO with registered output.
- Inputs: wr, rd, din.
- Outputs: dout, empty, full, occupancy.
- Asynchronous active-low reset.

The top level holds the classifier, counters and flow-control logic.

Test Plan:
1. strip_en=1; packet = hdr ctrl 'hFF, hdr ctrl 'h02, 3 payload words, EOP ctrl 'h10; out_rdy=1 -> output is 'hFF hdr, 3 payload, EOP (5 words); hdr_drop_cnt=1, pkt_cnt=1; first out_wr 2 cycles after first in_wr.
2. strip_en=0, same packet -> all 6 words out in order; hdr_drop_cnt=0, pkt_cnt=1.
3. FIFO_DEPTH=16, AF_MARGIN=3, out_rdy=0, continuous writes honouring in_rdy -> in_rdy falls when occupancy reaches 13; 3 further writes accepted; overflow=0. A 17th write -> overflow=1 and the word is absent from the output.
4. FIFO at 8 entries, simultaneous in_wr and out_rdy for 20 cycles -> occupancy stays 8; output order preserved; pointers wrap correctly.
5. reset driven low mid-packet, after 2 payload words -> FIFO empties, out_wr=0 immediately. The next word with ctrl 'h02 after reset release is treated as a header and dropped (in_pkt=0).
6. cnt_clr asserted in the same cycle as a header drop -> hdr_drop_cnt=0 the next cycle and overflow cleared.
